// File: rtl/mor1kx_dpram_arbiter_sclk.sv
// ---------------------------------------------------------------------------
// mor1kx_dpram_arbiter_sclk
//
// Write-port arbiter and clear sequencer for a single-clock simple dual-port
// RAM (separate read/write ports, 1-cycle registered read).
//  - Two write requesters (A, B) share the RAM write port round-robin.
//  - The read port is passed through and gated off while a clear runs.
//  - A hardware sweep writes CLEAR_VALUE to every address after reset
//    (when CLEAR_ON_RESET is set) or on a clear_req pulse.
//
// Optional feature macro: MOR1KX_DPRAM_ARB_STATS_EN
//  Defined   : conflict_cnt counts IDLE cycles in which A and B both request,
//              saturating at 16'hFFFF.
//  Undefined : conflict_cnt is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module mor1kx_dpram_arbiter_sclk #(
  parameter int unsigned           ADDR_WIDTH     = 6,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Requester A
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ack,
  // Requester B
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ack,
  // Read requester
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  // Clear control and status
  input  logic                  clear_req,
  output logic                  busy,
  output logic [15:0]           conflict_cnt,
  // RAM write port
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  // RAM read port
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Which requester received the most recent write ack.
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  // State registers
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  grant_t                r_last_grant;
  logic                  r_rd_valid;
  logic                  r_busy;

  // Next-state and decode wires
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] w_next_clr_addr;
  grant_t                w_next_last_grant;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_rd_grant;

  // State register: FSM, sweep pointer, round-robin pointer, read valid, busy.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others; blocking here would create ordering
  // dependent races between always_ff blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RESET_STATE;
      r_clr_addr   <= '0;
      r_last_grant <= GRANT_B;
      r_rd_valid   <= 1'b0;
      r_busy       <= CLEAR_ON_RESET;
    end else begin
      r_state      <= w_next_state;
      r_clr_addr   <= w_next_clr_addr;
      r_last_grant <= w_next_last_grant;
      r_rd_valid   <= w_rd_grant;
      r_busy       <= (w_next_state == S_CLEAR);
    end
  end

  // Next-state logic: arbitration in IDLE, address sweep in CLEAR.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state      = r_state;
    w_next_clr_addr   = r_clr_addr;
    w_next_last_grant = r_last_grant;
    w_grant_a         = 1'b0;
    w_grant_b         = 1'b0;
    w_rd_grant        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // On a tie the requester that was not served last wins.
        w_grant_a  = a_req & (~b_req | (r_last_grant == GRANT_B));
        w_grant_b  = b_req & ~w_grant_a;
        w_rd_grant = rd_req;

        if (w_grant_a) begin
          w_next_last_grant = GRANT_A;
        end else if (w_grant_b) begin
          w_next_last_grant = GRANT_B;
        end

        // The current cycle's writes and reads still go ahead; the sweep
        // begins on the following cycle.
        if (clear_req) begin
          w_next_state    = S_CLEAR;
          w_next_clr_addr = '0;
        end
      end

      S_CLEAR: begin
        // clear_req is ignored here: a running sweep is never restarted.
        // The pointer wraps back to zero after the all-ones address.
        w_next_clr_addr = r_clr_addr + ADDR_WIDTH'(1);
        if (&r_clr_addr) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // RAM port drive: sweep owns the write port in CLEAR, the winner in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = a_addr;
    ram_din   = a_data;

    if (r_state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = r_clr_addr;
      ram_din   = CLEAR_VALUE;
    end else begin
      ram_we = w_grant_a | w_grant_b;
      if (w_grant_b) begin
        ram_waddr = b_addr;
        ram_din   = b_data;
      end
    end
  end

  assign a_ack     = w_grant_a;
  assign b_ack     = w_grant_b;
  assign rd_ack    = w_rd_grant;
  assign ram_re    = w_rd_grant;
  assign ram_raddr = rd_addr;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;

`ifdef MOR1KX_DPRAM_ARB_STATS_EN
  logic        w_collision;
  logic [15:0] r_conflict_cnt;

  assign w_collision = (r_state == S_IDLE) & a_req & b_req;

  // Saturating collision counter; only reset clears it, clear_req does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_collision && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 16'h0;
`endif

endmodule
